// File: rtl/fcl_pro_stream.sv
// fcl_pro_stream: streaming first-layer binary fully-connected engine.
// Each accepted pixel is thermometer-encoded, XNORed against one weight bit
// per neuron, popcounted and accumulated over a frame; the frame result is
// shifted, saturated and presented on a valid/ready output.
module fcl_pro_stream #(
  parameter int PIX_WIDTH = 8,
  parameter int CH_CNT    = 16,
  parameter int PARALLEL  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int LEN_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [PIX_WIDTH-1:0]     in_pix,
  input  logic [PARALLEL-1:0]             in_w,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  input  logic [$clog2(ACC_WIDTH)-1:0]    cfg_shift,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PARALLEL*OUT_WIDTH-1:0]   out_data,
  output logic [PARALLEL-1:0]             out_sat,
  output logic                            busy
);

  localparam int SH_W     = $clog2(ACC_WIDTH);
  localparam int HALF     = CH_CNT / 2;
  localparam int KW       = PIX_WIDTH + $clog2(CH_CNT) + 2;
  localparam int PC_W     = $clog2(CH_CNT + 1);
  localparam int NEED_ACC = $clog2(HALF * (2 ** LEN_WIDTH)) + 2;

  localparam logic signed [ACC_WIDTH-1:0] O_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] O_MIN = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

  // The accumulator must never wrap over a maximal-length frame.
  if (ACC_WIDTH < NEED_ACC) begin : g_acc_width_chk
    $error("fcl_pro_stream: ACC_WIDTH too small for CH_CNT/LEN_WIDTH");
  end
  if ((CH_CNT < 2) || (CH_CNT % 2 != 0)) begin : g_ch_cnt_chk
    $error("fcl_pro_stream: CH_CNT must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_OUT
  } state_e;

  state_e                                state_q, state_d;
  logic [LEN_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]                  len_q, len_d;
  logic [SH_W-1:0]                       shift_q, shift_d;
  logic                                  ready_en_q;
  logic                                  s1_valid_q, s1_valid_d;
  logic [CH_CNT-1:0]                     s1_therm_q, s1_therm_d;
  logic [PARALLEL-1:0]                   s1_w_q, s1_w_d;
  logic [PARALLEL-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [PARALLEL-1:0][OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic [PARALLEL-1:0]                   out_sat_q, out_sat_d;

  logic                                  accept;
  logic                                  out_load;
  logic                                  out_hs;
  logic [LEN_WIDTH-1:0]                  cnt_inc;
  logic signed [KW-1:0]                  k_raw;
  logic signed [KW-1:0]                  k_cl;
  logic [CH_CNT-1:0]                     therm;
  logic [CH_CNT-1:0]                     xn;
  logic [PC_W-1:0]                       pc;
  logic [PARALLEL-1:0][ACC_WIDTH-1:0]    contrib;
  logic signed [ACC_WIDTH-1:0]           r;

  assign in_ready  = ready_en_q & ((state_q == S_IDLE) | (state_q == S_ACCUM));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_OUT);
  assign out_load  = (state_q == S_FLUSH) & ~s1_valid_q;
  assign out_hs    = (state_q == S_OUT) & out_ready;
  assign busy      = (state_q != S_IDLE) | s1_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  // Frame sequencing: beat counting, config latching and state transitions.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d   = cfg_len;
          shift_d = cfg_shift;
          cnt_d   = LEN_WIDTH'(1);
          state_d = (cfg_len <= LEN_WIDTH'(1)) ? S_FLUSH : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!s1_valid_q) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Thermometer encoding of the incoming pixel: k ones from the LSB.
  always_comb begin
    k_raw = KW'(HALF) + KW'(in_pix);
    k_cl  = k_raw;
    if (k_raw < 0) begin
      k_cl = '0;
    end else if (k_raw > KW'(CH_CNT)) begin
      k_cl = KW'(CH_CNT);
    end
    therm = '0;
    for (int j = 0; j < CH_CNT; j++) begin
      therm[j] = (k_cl > KW'(j));
    end
  end

  // Stage 1: capture the encoded pixel and weights on the accept edge.
  always_comb begin
    s1_valid_d = accept;
    s1_therm_d = s1_therm_q;
    s1_w_d     = s1_w_q;
    if (accept) begin
      s1_therm_d = therm;
      s1_w_d     = in_w;
    end
  end

  // Stage 2 datapath: XNOR, popcount and re-centre to a signed contribution.
  always_comb begin
    xn      = '0;
    pc      = '0;
    contrib = '0;
    for (int i = 0; i < PARALLEL; i++) begin
      xn = s1_w_q[i] ? s1_therm_q : ~s1_therm_q;
      pc = '0;
      for (int j = 0; j < CH_CNT; j++) begin
        pc = pc + PC_W'(xn[j]);
      end
      contrib[i] = ACC_WIDTH'(pc) - ACC_WIDTH'(HALF);
    end
  end

  // Accumulators: add stage-2 contributions, clear on the output handshake.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < PARALLEL; i++) begin
      if (out_hs) begin
        acc_d[i] = '0;
      end else if (s1_valid_q) begin
        acc_d[i] = acc_q[i] + contrib[i];
      end
    end
  end

  // Output formation: shift, saturate and load once the pipeline has drained.
  always_comb begin
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    r          = '0;
    if (out_load) begin
      for (int i = 0; i < PARALLEL; i++) begin
        r = $signed(acc_q[i]) >>> shift_q;
        if (r > O_MAX) begin
          out_data_d[i] = O_MAX[OUT_WIDTH-1:0];
          out_sat_d[i]  = 1'b1;
        end else if (r < O_MIN) begin
          out_data_d[i] = O_MIN[OUT_WIDTH-1:0];
          out_sat_d[i]  = 1'b1;
        end else begin
          out_data_d[i] = r[OUT_WIDTH-1:0];
          out_sat_d[i]  = 1'b0;
        end
      end
    end
  end

  // State, pipeline, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      ready_en_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_therm_q <= '0;
      s1_w_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      ready_en_q <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_therm_q <= s1_therm_d;
      s1_w_q     <= s1_w_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fcl_pro_stream.sv
// Scoreboard bench for fcl_pro_stream: the driver pushes the expected frame
// result computed from plain clamp/sum/shift arithmetic; a monitor compares
// every cycle the DUT presents out_valid and pops on the handshake.
module tb_fcl_pro_stream;

  localparam int PW = 8;
  localparam int CH = 16;
  localparam int P  = 4;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int LW = 10;
  localparam int SW = $clog2(AW);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_pix;
  logic [P-1:0]         in_w;
  logic [LW-1:0]        cfg_len;
  logic [SW-1:0]        cfg_shift;
  logic                 out_valid;
  logic                 out_ready;
  logic [P*OW-1:0]      out_data;
  logic [P-1:0]         out_sat;
  logic                 busy;

  typedef struct {
    logic [P*OW-1:0] data;
    logic [P-1:0]    sat;
  } exp_t;

  exp_t         exp_q[$];
  int           fr_pix[$];
  logic [P-1:0] fr_w[$];
  int           total = 0;
  int           bad   = 0;
  int           ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

  fcl_pro_stream #(
    .PIX_WIDTH(PW), .CH_CNT(CH), .PARALLEL(P),
    .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_w(in_w),
    .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each beat adds +/-clamp(pix, -CH/2, CH/2) per neuron.
  function automatic exp_t model(input int len_cfg, input int sh);
    exp_t e;
    int n;
    int acc;
    int c;
    int r;
    n = (len_cfg == 0) ? 1 : len_cfg;
    e.data = '0;
    e.sat  = '0;
    for (int i = 0; i < P; i++) begin
      acc = 0;
      for (int b = 0; b < n; b++) begin
        c = fr_pix[b];
        if (c > CH / 2) c = CH / 2;
        if (c < -CH / 2) c = -CH / 2;
        acc += fr_w[b][i] ? c : -c;
      end
      r = acc >>> sh;
      if (r > 127) begin
        r = 127;
        e.sat[i] = 1'b1;
      end else if (r < -128) begin
        r = -128;
        e.sat[i] = 1'b1;
      end
      e.data[i*OW +: OW] = r[OW-1:0];
    end
    return e;
  endfunction

  // Called at 1 time unit after a rising edge; returns the same way after the accept edge.
  task automatic send_beat(input int pix, input logic [P-1:0] w, input int len_cfg, input int sh);
    int guard;
    in_valid  = 1'b1;
    in_pix    = PW'(pix);
    in_w      = w;
    cfg_len   = LW'(len_cfg);
    cfg_shift = SW'(sh);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_pix    = PW'($urandom);
    cfg_len   = LW'($urandom);
    cfg_shift = SW'($urandom);
  endtask

  task automatic send_frame(input int len_cfg, input int sh, input bit bubbles);
    int n;
    n = (len_cfg == 0) ? 1 : len_cfg;
    for (int b = 0; b < n; b++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (b == 0) send_beat(fr_pix[b], fr_w[b], len_cfg, sh);
      else        send_beat(fr_pix[b], fr_w[b], int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
    end
    exp_q.push_back(model(len_cfg, sh));
  endtask

  task automatic fill_const(input int n, input int pix, input logic [P-1:0] w);
    fr_pix.delete();
    fr_w.delete();
    for (int b = 0; b < n; b++) begin
      fr_pix.push_back(pix);
      fr_w.push_back(w);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || busy) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: compare while out_valid, retire the entry on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_sat", out_sat, exp_q[0].sat);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int len_cfg;
    int sh;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_w      = '0;
    cfg_len   = '0;
    cfg_shift = '0;
    #2 rst = 1'b1;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);
    @(posedge clk);
    #1;

    // Single beat, mixed weights, with latency
    ready_mode = 2;
    fill_const(1, 3, 4'b0101);
    send_frame(1, 0, 0);
    @(negedge clk);
    check("lat_e0_out_valid", out_valid, 0);
    check("lat_e0_in_ready", in_ready, 0);
    check("lat_e0_busy", busy, 1);
    @(negedge clk);
    check("lat_e1_out_valid", out_valid, 0);
    @(negedge clk);
    check("lat_e2_out_valid", out_valid, 1);
    wait_drain();

    // Clamping: +8 then -8
    fr_pix.delete(); fr_w.delete();
    fr_pix.push_back(100);  fr_w.push_back(4'b1111);
    fr_pix.push_back(-100); fr_w.push_back(4'b1111);
    send_frame(2, 0, 0);
    wait_drain();

    // Accumulate and shift
    fill_const(4, 5, 4'b1111);
    send_frame(4, 1, 0);
    wait_drain();

    // Saturation both directions
    fill_const(32, 8, 4'b0011);
    send_frame(32, 0, 0);
    wait_drain();

    // Backpressure with a pending next-frame beat
    ready_mode = 1;
    fr_pix.delete(); fr_w.delete();
    for (int b = 0; b < 3; b++) begin
      fr_pix.push_back(int'($urandom_range(0, 40)) - 20);
      fr_w.push_back(P'($urandom));
    end
    send_frame(3, 0, 0);
    fill_const(1, -7, 4'b1001);
    in_valid  = 1'b1;
    in_pix    = PW'(-7);
    in_w      = 4'b1001;
    cfg_len   = LW'(1);
    cfg_shift = '0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready_low", in_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    ready_mode = 2;
    @(posedge clk);
    @(negedge clk);
    check("bp_handshake_ready", out_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp_next_in_ready", in_ready, 1);
    check("bp_out_valid_dropped", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(model(1, 0));
    wait_drain();

    // Reset mid-frame
    send_beat(50, 4'b1111, 4, 0);
    send_beat(50, 4'b1111, 4, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    fill_const(1, -2, 4'b1111);
    send_frame(1, 0, 0);
    wait_drain();

    // Random back-to-back frames with random bubbles and out_ready
    ready_mode = 0;
    for (int f = 0; f < 40; f++) begin
      len_cfg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 6));
      sh      = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      n       = (len_cfg == 0) ? 1 : len_cfg;
      fr_pix.delete(); fr_w.delete();
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 1) == 0) fr_pix.push_back(int'($urandom_range(0, 255)) - 128);
        else                           fr_pix.push_back(int'($urandom_range(0, 20)) - 10);
        fr_w.push_back(P'($urandom));
      end
      send_frame(len_cfg, sh, 1);
    end
    wait_drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
